multiplier: RTL
===============

# multiplier

Sequential shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It is the companion of the muldiv divider and sits beside it in the execute-stage muldiv unit. It uses the same start/done handshake and the same `muldiv_funct3_t` operation select. Operands are reduced to magnitudes, multiplied unsigned over 32 iterations, then sign-corrected, and the requested 32-bit half of the 64-bit product is returned.

## Interface
- No parameters. The datapath is fixed at 32 bits by RV32M.
- `clk`  input  1  sole clock; all state updates on posedge.
- `rst`  input  1  asynchronous, active-high reset.
- `sign`  input  `muldiv_funct3_t`  operation select: `mul`, `mulh`, `mulhsu` or `mulhu`. Any other encoding is treated as `mul`.
- `start`  input  1  request pulse; sampled only in IDLE.
- `op_a`  input  32  rs1 operand; sampled with `start`.
- `op_b`  input  32  rs2 operand; sampled with `start`.
- `product`  output  32  selected result half; registered.
- `done`  output  1  one-cycle pulse; `product` is valid from this cycle.
- `busy`  output  1  high in CALC and DONE.

## Operation
- States and transitions:
  - IDLE → CALC on `start`.
  - CALC → DONE when the iteration counter reaches 0.
  - DONE → IDLE unconditionally.
- Accepting `start` in IDLE latches the following:
  - `sign` (the operation).
  - a_neg = `op_a`[31] for `mulh`/`mulhsu`, else 0.
  - b_neg = `op_b`[31] for `mulh` only, else 0.
  - mag_a = a_neg ? −`op_a` : `op_a`, and mag_b = b_neg ? −`op_b` : `op_b`, both as 32-bit unsigned. −0x80000000 gives 0x80000000, which is the correct magnitude.
  - neg = a_neg ^ b_neg.
  - The 64-bit accumulator is cleared and the counter is set to 31.
- CALC performs one iteration per cycle, LSB first:
  - If the multiplier bit is set, the accumulator adds mag_a shifted left by the iteration index.
  - The counter decrements.
  - Addition is 64-bit. No overflow is possible, since the magnitude product is below 2^64.
- At the CALC → DONE edge:
  - p = neg ? −acc : acc (64-bit two's complement).
  - `product` = p[31:0] for `mul`, p[63:32] for the other three operations.
  - The register is written once.
- `product` holds its value through DONE and IDLE until the next accepted `start` completes. It is not cleared on `start`.
- `start` is ignored while `busy`. It has no effect and is not queued.
- Changes on `op_a`, `op_b` or `sign` after the `start` cycle have no effect on the result in flight.
- `mul` result is independent of operand signedness. It is computed as unsigned (neg = 0).
- Zero operand: the full 32 iterations still run. There is no early termination, so latency is fixed.

## Timing
- Reset state: `state` = IDLE, `done` = 0, `busy` = 0, `product` = 0x00000000, accumulator and counter = 0.
- Reset takes effect immediately (asynchronous).
- Assertion mid-operation aborts the computation. Nothing is written and no `done` pulse follows.
- Latency:
  - `start` high in IDLE during cycle T.
  - CALC occupies cycles T+1 through T+32.
  - `done` = 1 and `busy` = 1 in cycle T+33, with `product` valid.
  - IDLE in cycle T+34.
- `done` is exactly one cycle wide and is never asserted outside DONE.
- Back-to-back: the earliest next `start` that is accepted is in cycle T+34, giving a throughput of 1 op per 34 cycles.
- `start` asserted in DONE (cycle T+33) is ignored.
- `done`, `busy` and `product` are all driven from registers. There are no combinational paths from inputs to outputs.

## Test plan
- `mul`, 7 × 6, `start` in cycle T:
  - `product` = 0x0000002A.
  - `done` high only in cycle T+33; `busy` high T+1..T+33.
- `mulh`, 0x80000000 × 0x80000000 → `product` = 0x40000000. Then `mul` on the same operands → 0x00000000.
- `mulh`, 0xFFFFFFFD (−3) × 0x00000005 → 0xFFFFFFFF. Then `mul` on the same operands → 0xFFFFFFF1.
- `mulhsu`, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- `mulhu`, 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Then `mul` on the same operands → 0x00000001.
- Robustness sequence:
  - Change `op_a`/`op_b` and pulse `start` mid-CALC → no effect; the original result is returned and only one `done` pulse occurs.
  - Assert `rst` at cycle T+10 → `busy` = 0, `done` never pulses, `product` = 0.
  - A fresh `start` after reset completes normally at +33 cycles.

Source files
------------

// File: rtl/multiplier.sv
// multiplier: sequential shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU
package muldiv_pkg;
  typedef enum logic [2:0] {
    mul    = 3'd0,
    mulh   = 3'd1,
    mulhsu = 3'd2,
    mulhu  = 3'd3,
    div    = 3'd4,
    divu   = 3'd5,
    rem    = 3'd6,
    remu   = 3'd7
  } muldiv_funct3_t;
endpackage

module multiplier
  import muldiv_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  muldiv_funct3_t sign,
  input  logic           start,
  input  logic [31:0]    op_a,
  input  logic [31:0]    op_b,
  output logic [31:0]    product,
  output logic           done,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state;
  logic        hi, neg, a_neg, b_neg;
  logic [4:0]  cnt;
  logic [31:0] b_sh;
  logic [63:0] acc, a_sh, acc_nxt, p;
  // operand sign decode and the next partial sum with final sign correction
  always_comb begin
    a_neg   = (sign == mulh || sign == mulhsu) && op_a[31];
    b_neg   = (sign == mulh) && op_b[31];
    acc_nxt = acc + (b_sh[0] ? a_sh : 64'd0);
    p       = neg ? -acc_nxt : acc_nxt;
  end
  // control FSM and datapath; mag_a is kept pre-shifted and mag_b consumed LSB first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      hi      <= 1'b0;
      neg     <= 1'b0;
      cnt     <= 5'd0;
      b_sh    <= 32'd0;
      a_sh    <= 64'd0;
      acc     <= 64'd0;
      product <= 32'd0;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else
      case (state)
        IDLE: if (start) begin
          state <= CALC;
          busy  <= 1'b1;
          hi    <= sign == mulh || sign == mulhsu || sign == mulhu;
          neg   <= a_neg ^ b_neg;
          a_sh  <= {32'd0, a_neg ? -op_a : op_a};
          b_sh  <= b_neg ? -op_b : op_b;
          acc   <= 64'd0;
          cnt   <= 5'd31;
        end
        CALC: begin
          acc  <= acc_nxt;
          a_sh <= a_sh << 1;
          b_sh <= b_sh >> 1;
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            state   <= DONE;
            done    <= 1'b1;
            product <= hi ? p[63:32] : p[31:0];
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
endmodule
